// File: rtl/uop_fetch_queue.sv
// Decoupling FIFO between uop fetch and decode/rename: two-wide push, up to two-wide pop.
// Optional FETCH_QUEUE_STATS_EN adds stall_cycles and high_water statistics outputs.

package uop_fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetched_instruction;
endpackage

module uop_fetch_queue
  import uop_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   prev_valid,
  input  fetched_instruction     in_1,
  input  fetched_instruction     in_2,
  output logic                   stalled,
  input  logic                   next_stalled,
  output logic                   valid_1,
  output logic                   valid_2,
  output fetched_instruction     out_1,
  output fetched_instruction     out_2,
  output logic                   overflow
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]            stall_cycles,
  output logic [$clog2(DEPTH):0] high_water
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   pop_cnt;
  logic               space_ok;
  logic               push;
  fetched_instruction mem [DEPTH];

  // Head-of-queue view and push/pop decisions, all from pre-edge state
  always_comb begin
    valid_1    = (count != '0);
    valid_2    = (count >= CNT_W'(2));
    out_1      = mem[head];
    out_2      = mem[head + PTR_W'(1)];
    pop_cnt    = '0;
    if (!next_stalled) begin
      if (valid_2)      pop_cnt = CNT_W'(2);
      else if (valid_1) pop_cnt = CNT_W'(1);
    end
    space_ok   = (count <= CNT_W'(DEPTH - 2));
    push       = prev_valid && space_ok;
    count_next = count + (push ? CNT_W'(2) : CNT_W'(0)) - pop_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      stalled  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      head    <= head + PTR_W'(pop_cnt);
      if (push) tail <= tail + PTR_W'(2);
      count   <= count_next;
      // Threshold leaves room for two more pairs already in flight from fetch
      stalled <= (count_next > CNT_W'(DEPTH - 4));
      if (prev_valid && !space_ok) overflow <= 1'b1;
    end
  end

  // Storage is not reset; only pointers/count define liveness
  always_ff @(posedge clk) begin
    if (!reset && !clear && push) begin
      mem[tail]              <= in_1;
      mem[tail + PTR_W'(1)]  <= in_2;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  // Statistics survive a pipeline clear; only reset zeroes them
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      high_water   <= '0;
    end else begin
      if (stalled && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (!clear && (count_next > high_water)) high_water <= count_next;
    end
  end
`endif

endmodule
